// File: rtl/bms_pkg.sv
// Shared types and sizing for the bank match sequencer.
package bms_pkg;

  localparam int unsigned NFIELD_DEF = 10;
  localparam int unsigned NBANK_DEF  = 3;
  localparam int unsigned BANK_IDX_W = 2;
  localparam int unsigned SETTLE_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/field_match_unit.sv
// Selects one bank from the flattened bank bus and compares it field-by-field with the key.
module field_match_unit
  import bms_pkg::*;
#(
  parameter int unsigned NFIELD = NFIELD_DEF,
  parameter int unsigned NBANK  = NBANK_DEF
) (
  input  logic [NBANK*NFIELD-1:0] bank_data,
  input  logic [BANK_IDX_W-1:0]   bank_idx,
  input  logic [NFIELD-1:0]       key,
  output logic                    match_c
);

  logic [NFIELD-1:0] sel_data;
  logic [NFIELD-1:0] diff;

  // Mux by comparison so an out-of-range index never slices past the bus.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      if (bank_idx == BANK_IDX_W'(i)) begin
        sel_data = bank_data[i*NFIELD +: NFIELD];
      end
    end
    diff    = sel_data ^ key;
    match_c = ~|diff;
  end

endmodule

// File: rtl/bank_match_sequencer.sv
// Walks a one-hot bank select across NBANK banks, settling on each before comparing
// against a latched key; stops at the first match and updates a guarded sticky hold bit.
module bank_match_sequencer
  import bms_pkg::*;
#(
  parameter int unsigned NFIELD = NFIELD_DEF,
  parameter int unsigned NBANK  = NBANK_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    CK,
  input  logic                    RSTn,
  input  logic                    start,
  input  logic [NFIELD-1:0]       key,
  input  logic [NBANK*NFIELD-1:0] bank_data,
  input  logic                    en_a,
  input  logic                    en_b,
  input  logic                    inhibit,
  output logic [NBANK-1:0]        bank_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    hit,
  output logic [BANK_IDX_W-1:0]   hit_bank,
  output logic                    hold
);

  if (NBANK == 0 || NBANK > (1 << BANK_IDX_W)) begin : g_nbank_range
    $error("bank_match_sequencer: NBANK must be 1..4");
  end
  if (SETTLE > ((1 << SETTLE_W) - 1)) begin : g_settle_range
    $error("bank_match_sequencer: SETTLE must be 0..7");
  end

  state_e                  state_q, state_d;
  logic [BANK_IDX_W-1:0]   b_q, b_d;
  logic [SETTLE_W-1:0]     c_q, c_d;
  logic [NFIELD-1:0]       key_q, key_d;
  logic                    guard_q, guard_d;
  logic [NBANK-1:0]        bank_sel_d;
  logic                    busy_d, done_d, hit_d, hold_d;
  logic [BANK_IDX_W-1:0]   hit_bank_d;
  logic                    match_c;

  field_match_unit #(
    .NFIELD (NFIELD),
    .NBANK  (NBANK)
  ) u_match (
    .bank_data (bank_data),
    .bank_idx  (b_q),
    .key       (key_q),
    .match_c   (match_c)
  );

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    c_d        = c_q;
    key_d      = key_q;
    guard_d    = guard_q;
    hit_d      = hit;
    hit_bank_d = hit_bank;
    hold_d     = hold;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d      = key;
          guard_d    = en_a & en_b & ~inhibit;
          hit_d      = 1'b0;
          hit_bank_d = '0;
          b_d        = '0;
          c_d        = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (c_q != SETTLE_W'(SETTLE)) begin
          c_d = c_q + SETTLE_W'(1);
        end else if (match_c) begin
          hit_d      = 1'b1;
          hit_bank_d = b_q;
          state_d    = DONE;
        end else if (b_q == BANK_IDX_W'(NBANK - 1)) begin
          hit_d      = 1'b0;
          hit_bank_d = '0;
          state_d    = DONE;
        end else begin
          b_d = b_q + BANK_IDX_W'(1);
          c_d = '0;
        end
      end
      DONE: begin
        if (guard_q) begin
          hold_d = hit;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Derived from the next state so select, busy and done align with it.
    bank_sel_d = (state_d == SCAN) ? (NBANK'(1) << b_d) : '0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      b_q      <= '0;
      c_q      <= '0;
      key_q    <= '0;
      guard_q  <= 1'b0;
      bank_sel <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      hit_bank <= '0;
      hold     <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      c_q      <= c_d;
      key_q    <= key_d;
      guard_q  <= guard_d;
      bank_sel <= bank_sel_d;
      busy     <= busy_d;
      done     <= done_d;
      hit      <= hit_d;
      hit_bank <= hit_bank_d;
      hold     <= hold_d;
    end
  end

endmodule

// File: tb/tb_bank_match_sequencer.sv
// Directed bench for bank_match_sequencer: scan timing, hit/miss, guard, start filtering, async reset.
module tb_bank_match_sequencer;

  localparam int unsigned NFIELD = 10;
  localparam int unsigned NBANK  = 3;
  localparam int unsigned SETTLE = 1;

  logic                    CK;
  logic                    RSTn;
  logic                    start;
  logic [NFIELD-1:0]       key;
  logic [NBANK*NFIELD-1:0] bank_data;
  logic                    en_a, en_b, inhibit;
  logic [NBANK-1:0]        bank_sel;
  logic                    busy, done, hit, hold;
  logic [1:0]              hit_bank;

  int   vectors;
  int   miscompares;
  logic hold_m;

  bank_match_sequencer #(
    .NFIELD (NFIELD),
    .NBANK  (NBANK),
    .SETTLE (SETTLE)
  ) dut (
    .CK        (CK),
    .RSTn      (RSTn),
    .start     (start),
    .key       (key),
    .bank_data (bank_data),
    .en_a      (en_a),
    .en_b      (en_b),
    .inhibit   (inhibit),
    .bank_sel  (bank_sel),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_bank  (hit_bank),
    .hold      (hold)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic test_reset();
    RSTn = 1'b0; start = 1'b0; key = '0; bank_data = '0;
    en_a = 1'b0; en_b = 1'b0; inhibit = 1'b0;
    hold_m = 1'b0;
    #2;
    vectors++;
    if ({bank_sel, busy, done, hit, hit_bank, hold} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got sel=%b busy=%b done=%b hit=%b bank=%0d hold=%b exp all 0",
               bank_sel, busy, done, hit, hit_bank, hold);
    end
    @(negedge CK); @(negedge CK);
    RSTn = 1'b1;
    @(negedge CK);
    vectors++;
    if ({bank_sel, busy, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got sel=%b busy=%b done=%b exp 0", bank_sel, busy, done);
    end
  endtask

  // One complete scan; inputs other than bank_data are scrambled after the start cycle.
  task automatic run_scan(input logic [9:0] k, input logic [9:0] d0, input logic [9:0] d1,
                          input logic [9:0] d2, input logic ga, input logic gb, input logic inh,
                          input logic exp_hit, input logic [1:0] exp_bank, input bit repulse,
                          input string name);
    int       nb;
    int       lat;
    logic [2:0] exp_sel;
    nb  = exp_hit ? int'(exp_bank) + 1 : int'(NBANK);
    lat = 1 + nb * int'(SETTLE + 1);
    @(posedge CK); #1;
    key = k; bank_data = {d2, d1, d0};
    en_a = ga; en_b = gb; inhibit = inh; start = 1'b1;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge CK); #1;
      start = repulse; key = ~k; en_a = ~ga; en_b = ~gb; inhibit = ~inh;
      @(negedge CK);
      exp_sel = (cyc < lat) ? 3'(1 << ((cyc - 1) / int'(SETTLE + 1))) : 3'b000;
      vectors++;
      if (bank_sel !== exp_sel) begin
        miscompares++;
        $display("FAIL %s bank_sel cyc %0d got %b exp %b", name, cyc, bank_sel, exp_sel);
      end
      vectors++;
      if (done !== logic'(cyc == lat) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s done/busy cyc %0d got %b/%b exp %b/1", name, cyc, done, busy,
                 logic'(cyc == lat));
      end
    end
    vectors++;
    if (hit !== exp_hit || hit_bank !== exp_bank) begin
      miscompares++;
      $display("FAIL %s result got hit=%b bank=%0d exp hit=%b bank=%0d",
               name, hit, hit_bank, exp_hit, exp_bank);
    end
    if (ga & gb & ~inh) hold_m = exp_hit;
    @(posedge CK); #1;
    start = 1'b0;
    @(negedge CK);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || bank_sel !== 3'b000 || hold !== hold_m) begin
      miscompares++;
      $display("FAIL %s post got done=%b busy=%b sel=%b hold=%b exp 0/0/000/%b",
               name, done, busy, bank_sel, hold, hold_m);
    end
  endtask

  task automatic test_single_hit();
    run_scan(10'h2A5, 10'h2A5, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "hit_bank0");
  endtask

  task automatic test_walk();
    run_scan(10'h155, 10'h000, 10'h3FF, 10'h155, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "hit_bank2");
    run_scan(10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, "first_of_two");
  endtask

  task automatic test_miss();
    run_scan(10'h0AA, 10'h000, 10'h3FF, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "miss");
  endtask

  task automatic test_guard();
    run_scan(10'h0F0, 10'h000, 10'h0F0, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, "guard_hit");
    run_scan(10'h111, 10'h000, 10'h3FF, 10'h155, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, "inhibit_miss");
    run_scan(10'h111, 10'h000, 10'h3FF, 10'h155, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "guard_miss");
  endtask

  task automatic test_back_to_back();
    run_scan(10'h155, 10'h000, 10'h3FF, 10'h155, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, "repulse");
    run_scan(10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "after_repulse");
  endtask

  task automatic test_reset_midscan();
    @(posedge CK); #1;
    key = 10'h3FF; bank_data = {10'h3FF, 10'h000, 10'h000};
    en_a = 1'b1; en_b = 1'b1; inhibit = 1'b0; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    @(posedge CK);
    @(posedge CK); #1;
    vectors++;
    if (bank_sel !== 3'b010 || hold !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset got sel=%b hold=%b exp 010/1", bank_sel, hold);
    end
    #2;
    RSTn = 1'b0;
    #1;
    vectors++;
    if (bank_sel !== 3'b000 || busy !== 1'b0 || hit !== 1'b0 || hold !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got sel=%b busy=%b hit=%b hold=%b done=%b exp all 0",
               bank_sel, busy, hit, hold, done);
    end
    hold_m = 1'b0;
    @(negedge CK); #2;
    RSTn = 1'b1;
    run_scan(10'h3FF, 10'h000, 10'h000, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, "fresh_scan");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_hit();
    test_walk();
    test_miss();
    test_guard();
    test_back_to_back();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
